// File: rtl/output_format_stage_if.sv
// Result-path bus between the BKM iteration core, the output format stage
// and the FPU result port. Carries the upstream beat (valid/ready, format tag,
// X/Y lanes) and the downstream formatted beat (valid/ready, lanes, tag, flags).
// slave  : the format stage itself
// master : the environment that feeds beats in and drains results out
interface output_format_stage_if #(
   parameter int W = 64
) ();

   logic         s_valid;
   logic         s_ready;
   logic [2:0]   format;
   logic [W-1:0] X_in;
   logic [W-1:0] Y_in;

   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] X_out;
   logic [W-1:0] Y_out;
   logic [2:0]   fmt_out;
   logic [1:0]   ovf_out;
   logic         err_out;

   modport slave (
      input  s_valid, format, X_in, Y_in, m_ready,
      output s_ready, m_valid, X_out, Y_out, fmt_out, ovf_out, err_out
   );

   modport master (
      output s_valid, format, X_in, Y_in, m_ready,
      input  s_ready, m_valid, X_out, Y_out, fmt_out, ovf_out, err_out
   );

endinterface

// File: rtl/output_format_stage.sv
// Registered, flow-controlled output precision/format stage for the BKM FPU
// result path. Each accepted beat is formatted on the way in (narrowing to
// W/2 for 32-bit formats, zeroing Y for real formats, flagging invalid tags)
// and then held in a two-entry buffer: the output register plus one skid
// register, so s_ready never depends combinationally on m_ready.
// Overflowed lanes are counted at acceptance time in a saturating counter.
module output_format_stage #(
   parameter int W      = 64,
   parameter bit SAT_EN = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               srst,
   input  logic               enable,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   sat_cnt,
   output_format_stage_if.slave bus
);

   localparam int H   = W / 2;
   localparam int CW1 = CNT_W + 1;

   typedef enum logic [2:0] {
      FMT_REAL_32  = 3'd0,
      FMT_REAL_64  = 3'd1,
      FMT_CMPLX_32 = 3'd2,
      FMT_CMPLX_64 = 3'd3
   } fmt_e;

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [2:0]   fmt;
      logic [1:0]   ovf;
      logic         err;
   } beat_t;

   beat_t            out_q, out_d;
   beat_t            skid_q, skid_d;
   logic             outValid_q, outValid_d;
   logic             skidValid_q, skidValid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   beat_t            newBeat;
   logic [W:0]       narX;
   logic [W:0]       narY;
   logic             sReady;
   logic             accept;
   logic             pop;
   logic [CW1-1:0]   cntSum;

   // Narrow one lane to W/2 bits; result is {overflow, sign-extended value}.
   // A lane fits when its top H+1 bits are all equal (pure sign extension).
   function automatic logic [W:0] narrowLane(input logic [W-1:0] v);
      logic [H:0] top;
      logic       fits;
      top  = v[W-1:H-1];
      fits = (&top) | ~(|top);
      if (fits) begin
         narrowLane = {1'b0, v};
      end else if (SAT_EN) begin
         if (v[W-1]) begin
            narrowLane = {1'b1, {(H+1){1'b1}}, {(H-1){1'b0}}};
         end else begin
            narrowLane = {1'b1, {(H+1){1'b0}}, {(H-1){1'b1}}};
         end
      end else begin
         narrowLane = {1'b1, {H{v[H-1]}}, v[H-1:0]};
      end
   endfunction

   // Space exists while the skid is empty; the output register can always
   // take a beat then, because it either is empty or drains into nothing.
   assign sReady = enable & ~skidValid_q;
   assign accept = bus.s_valid & sReady;
   assign pop    = outValid_q & bus.m_ready & enable;

   // Format the incoming beat according to its tag.
   always_comb begin
      narX        = narrowLane(bus.X_in);
      narY        = narrowLane(bus.Y_in);
      newBeat     = '0;
      newBeat.fmt = bus.format;
      case (bus.format)
         FMT_REAL_32: begin
            newBeat.x      = narX[W-1:0];
            newBeat.ovf[0] = narX[W];
         end
         FMT_REAL_64: begin
            newBeat.x = bus.X_in;
         end
         FMT_CMPLX_32: begin
            newBeat.x   = narX[W-1:0];
            newBeat.y   = narY[W-1:0];
            newBeat.ovf = {narY[W], narX[W]};
         end
         FMT_CMPLX_64: begin
            newBeat.x = bus.X_in;
            newBeat.y = bus.Y_in;
         end
         default: begin
            newBeat.err = 1'b1;
         end
      endcase
   end

   // Buffer and counter next-state: strict FIFO order through the output
   // register and skid; the skid refills the output register on a pop.
   // A clear in the same cycle as an accept wins over the increment.
   always_comb begin
      out_d       = out_q;
      skid_d      = skid_q;
      outValid_d  = outValid_q;
      skidValid_d = skidValid_q;
      cnt_d       = cnt_q;
      cntSum      = {1'b0, cnt_q} + CW1'(newBeat.ovf[0]) + CW1'(newBeat.ovf[1]);
      if (enable) begin
         if (pop) begin
            if (skidValid_q) begin
               out_d       = skid_q;
               skidValid_d = 1'b0;
            end else if (accept) begin
               out_d = newBeat;
            end else begin
               outValid_d = 1'b0;
            end
         end else if (accept) begin
            if (!outValid_q) begin
               out_d      = newBeat;
               outValid_d = 1'b1;
            end else begin
               skid_d      = newBeat;
               skidValid_d = 1'b1;
            end
         end
         if (cnt_clr) begin
            cnt_d = '0;
         end else if (accept) begin
            cnt_d = cntSum[CNT_W] ? {CNT_W{1'b1}} : cntSum[CNT_W-1:0];
         end
      end
   end

   // State registers; synchronous reset drops any buffered beats.
   always_ff @(posedge clk) begin
      if (srst) begin
         out_q       <= '0;
         skid_q      <= '0;
         outValid_q  <= 1'b0;
         skidValid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         out_q       <= out_d;
         skid_q      <= skid_d;
         outValid_q  <= outValid_d;
         skidValid_q <= skidValid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.s_ready = sReady;
   assign bus.m_valid = outValid_q;
   assign bus.X_out   = out_q.x;
   assign bus.Y_out   = out_q.y;
   assign bus.fmt_out = out_q.fmt;
   assign bus.ovf_out = out_q.ovf;
   assign bus.err_out = out_q.err;
   assign sat_cnt     = cnt_q;

endmodule
